// File: rtl/prewish_pkg.sv
// prewish_pkg
// Shared definitions for the mentor -> blinky strobe/data link.
//   DEFAULT_MASK_W : default blink-mask width
//   state_e        : receiver FSM encoding (IDLE / RUN)
//   MASK_ALT       : alternating pattern shared with the mentor and benches
package prewish_pkg;

    localparam int DEFAULT_MASK_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [7:0] MASK_ALT = 8'b10101010;

endpackage

// File: rtl/prewish_prescaler.sv
// prewish_prescaler
// Divides the system clock down to one tick per blink-mask bit.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   clear  : forces the count back to 0 (wins over enable)
//   enable : count 0..TICK_DIV-1 while high
//   tick   : one-cycle pulse on the terminal count
module prewish_prescaler #(
    parameter int TICK_DIV = 1500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] TERM = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             at_term;

    assign at_term = (cnt_q == TERM);

    // A clear on the terminal-count cycle suppresses the tick, so a
    // coincident reload never also advances the bit index.
    assign tick = enable & ~clear & at_term;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = at_term ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/prewish_blinky_rx.sv
// prewish_blinky_rx
// Receiving end of the mentor -> blinky link. Captures a blink mask on the
// rising edge of STB_I, acknowledges it with a one-cycle ACK_O pulse and
// replays the mask MSB-first onto o_led, one bit per TICK_DIV clocks,
// wrapping forever. A zero mask returns the block to IDLE.
// Ports:
//   CLK_I  : system clock, rising edge
//   RST_I  : asynchronous active-low reset
//   STB_I  : load strobe, rising edge marks a new mask on DAT_I
//   DAT_I  : blink mask
//   ACK_O  : one-cycle load acknowledge
//   o_led  : LED drive, active-high, registered
//   o_busy : high while in RUN, registered
// Build option: define PREWISH_RX_SYNC_EN to pass STB_I/DAT_I through a
// 2-flop synchronizer (adds 2 cycles of latency). Without it the inputs
// must be synchronous to CLK_I.
module prewish_blinky_rx
    import prewish_pkg::*;
#(
    parameter int MASK_W   = DEFAULT_MASK_W,
    parameter int TICK_DIV = 1500000
) (
    input  logic              CLK_I,
    input  logic              RST_I,
    input  logic              STB_I,
    input  logic [MASK_W-1:0] DAT_I,
    output logic              ACK_O,
    output logic              o_led,
    output logic              o_busy
);

    localparam int BIT_W = $clog2(MASK_W);
    localparam logic [BIT_W-1:0] BIT_MSB = BIT_W'(MASK_W - 1);

    logic              stb_s;
    logic [MASK_W-1:0] dat_s;

`ifdef PREWISH_RX_SYNC_EN
    logic [1:0]        stb_sync_q;
    logic [1:0]        stb_sync_d;
    logic [MASK_W-1:0] dat_sync1_q;
    logic [MASK_W-1:0] dat_sync1_d;
    logic [MASK_W-1:0] dat_sync2_q;
    logic [MASK_W-1:0] dat_sync2_d;

    always_comb begin
        stb_sync_d  = {stb_sync_q[0], STB_I};
        dat_sync1_d = DAT_I;
        dat_sync2_d = dat_sync1_q;
    end

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            stb_sync_q  <= '0;
            dat_sync1_q <= '0;
            dat_sync2_q <= '0;
        end else begin
            stb_sync_q  <= stb_sync_d;
            dat_sync1_q <= dat_sync1_d;
            dat_sync2_q <= dat_sync2_d;
        end
    end

    assign stb_s = stb_sync_q[1];
    assign dat_s = dat_sync2_q;
`else
    assign stb_s = STB_I;
    assign dat_s = DAT_I;
`endif

    state_e            state_q;
    state_e            state_d;
    logic [MASK_W-1:0] mask_q;
    logic [MASK_W-1:0] mask_d;
    logic [BIT_W-1:0]  bit_idx_q;
    logic [BIT_W-1:0]  bit_idx_d;
    logic              stb_prev_q;
    logic              stb_prev_d;
    logic              ack_q;
    logic              ack_d;
    logic              led_q;
    logic              led_d;
    logic              busy_q;
    logic              busy_d;

    logic load;
    logic tick;
    logic pre_clear;
    logic pre_enable;

    // A held strobe produces a single load: only the low-to-high transition counts.
    assign load = stb_s & ~stb_prev_q;

    // The prescaler sits at 0 in IDLE and restarts on every load.
    assign pre_enable = (state_q == RUN);
    assign pre_clear  = load | (state_q != RUN);

    prewish_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk    (CLK_I),
        .rst_n  (RST_I),
        .clear  (pre_clear),
        .enable (pre_enable),
        .tick   (tick)
    );

    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        bit_idx_d  = bit_idx_q;
        stb_prev_d = stb_s;
        ack_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (load) begin
                    ack_d = 1'b1;
                    if (dat_s != '0) begin
                        state_d   = RUN;
                        mask_d    = dat_s;
                        bit_idx_d = BIT_MSB;
                    end
                end
            end
            RUN: begin
                if (load) begin
                    ack_d     = 1'b1;
                    bit_idx_d = BIT_MSB;
                    if (dat_s != '0) begin
                        mask_d = dat_s;
                    end else begin
                        state_d = IDLE;
                        mask_d  = '0;
                    end
                end else if (tick) begin
                    bit_idx_d = (bit_idx_q == '0) ? BIT_MSB : bit_idx_q - BIT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are computed from next-state values so the new MSB appears
        // on the same edge that captures the mask.
        busy_d = (state_d == RUN);
        led_d  = (state_d == RUN) ? mask_d[bit_idx_d] : 1'b0;
    end

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state_q    <= IDLE;
            mask_q     <= '0;
            bit_idx_q  <= BIT_MSB;
            stb_prev_q <= 1'b0;
            ack_q      <= 1'b0;
            led_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            bit_idx_q  <= bit_idx_d;
            stb_prev_q <= stb_prev_d;
            ack_q      <= ack_d;
            led_q      <= led_d;
            busy_q     <= busy_d;
        end
    end

    assign ACK_O  = ack_q;
    assign o_led  = led_q;
    assign o_busy = busy_q;

endmodule

// File: tb/tb_prewish_blinky_rx.sv
// tb_prewish_blinky_rx
// Directed bench for prewish_blinky_rx with TICK_DIV=4. Expected LED
// sequences are derived from the loaded masks; the synchronizer build
// shifts every expectation by two cycles.
module tb_prewish_blinky_rx;
    import prewish_pkg::*;

    localparam int TICK_DIV = 4;
`ifdef PREWISH_RX_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic       CLK_I = 1'b0;
    logic       RST_I = 1'b0;
    logic       STB_I = 1'b0;
    logic [7:0] DAT_I = 8'h00;
    logic       ACK_O;
    logic       o_led;
    logic       o_busy;

    int n_cmp  = 0;
    int n_fail = 0;

    prewish_blinky_rx #(
        .MASK_W   (8),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .CLK_I  (CLK_I),
        .RST_I  (RST_I),
        .STB_I  (STB_I),
        .DAT_I  (DAT_I),
        .ACK_O  (ACK_O),
        .o_led  (o_led),
        .o_busy (o_busy)
    );

    always #5 CLK_I = ~CLK_I;

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge CLK_I);
        #1;
    endtask

    task automatic do_reset();
        RST_I = 1'b0;
        STB_I = 1'b0;
        DAT_I = 8'h00;
        step();
        step();
        RST_I = 1'b1;
        step();
    endtask

    task automatic test_reset();
        RST_I = 1'b0;
        STB_I = 1'b0;
        DAT_I = 8'h00;
        repeat (5) step();
        n_cmp++;
        if ({ACK_O, o_led, o_busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_hold: got {ack,led,busy}=%b want 000", {ACK_O, o_led, o_busy});
        end
        RST_I = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            n_cmp++;
            if ({ACK_O, o_led, o_busy} !== 3'b000) begin
                n_fail++;
                $display("FAIL reset_idle c=%0d: got {ack,led,busy}=%b want 000", c, {ACK_O, o_led, o_busy});
            end
        end
    endtask

    task automatic test_pattern();
        logic [7:0] m;
        logic       exp_led;
        logic       exp_ack;
        logic       exp_busy;
        int         k;
        m = 8'b10110100;
        do_reset();
        DAT_I = m;
        STB_I = 1'b1;
        for (int c = 0; c < LAT + 40; c++) begin
            step();
            if (c == 0) STB_I = 1'b0;
            k = c - LAT;
            exp_ack  = (k == 0);
            exp_busy = (k >= 0);
            exp_led  = (k >= 0) ? m[7 - ((k / TICK_DIV) % 8)] : 1'b0;
            n_cmp++;
            if ({ACK_O, o_led, o_busy} !== {exp_ack, exp_led, exp_busy}) begin
                n_fail++;
                $display("FAIL pattern c=%0d: got {ack,led,busy}=%b want %b", c,
                         {ACK_O, o_led, o_busy}, {exp_ack, exp_led, exp_busy});
            end
        end
    endtask

    task automatic test_held_strobe();
        logic exp_led;
        logic exp_ack;
        int   k;
        do_reset();
        DAT_I = 8'hF0;
        STB_I = 1'b1;
        for (int c = 0; c < LAT + 40; c++) begin
            step();
            if (c == 5) STB_I = 1'b0;
            k = c - LAT;
            exp_ack = (k == 0);
            exp_led = (k >= 0) && ((k % 32) < 16);
            n_cmp++;
            if ({ACK_O, o_led} !== {exp_ack, exp_led}) begin
                n_fail++;
                $display("FAIL held_strobe c=%0d: got {ack,led}=%b want %b", c,
                         {ACK_O, o_led}, {exp_ack, exp_led});
            end
        end
    endtask

    task automatic test_midrun_reload();
        logic [7:0] m;
        logic       exp_led;
        logic       exp_ack;
        logic       exp_busy;
        int         k;
        int         j;
        m = MASK_ALT;
        do_reset();
        DAT_I = m;
        STB_I = 1'b1;
        for (int c = 0; c < LAT + 56; c++) begin
            step();
            if (c == 0) STB_I = 1'b0;
            if (c == 19) begin
                DAT_I = 8'h01;
                STB_I = 1'b1;
            end
            if (c == 20) STB_I = 1'b0;
            k = c - LAT;
            exp_busy = (k >= 0);
            if (k < 0) begin
                exp_ack = 1'b0;
                exp_led = 1'b0;
            end else if (k < 20) begin
                exp_ack = (k == 0);
                exp_led = m[7 - (k / TICK_DIV)];
            end else begin
                j = k - 20;
                exp_ack = (j == 0);
                exp_led = ((j % 32) >= 28);
            end
            n_cmp++;
            if ({ACK_O, o_led, o_busy} !== {exp_ack, exp_led, exp_busy}) begin
                n_fail++;
                $display("FAIL midrun_reload c=%0d: got {ack,led,busy}=%b want %b", c,
                         {ACK_O, o_led, o_busy}, {exp_ack, exp_led, exp_busy});
            end
        end
    endtask

    task automatic test_load_zero();
        do_reset();
        // Zero load while idle: acknowledged, no run.
        DAT_I = 8'h00;
        STB_I = 1'b1;
        for (int c = 0; c <= LAT; c++) begin
            step();
            if (c == 0) STB_I = 1'b0;
        end
        n_cmp++;
        if ({ACK_O, o_led, o_busy} !== 3'b100) begin
            n_fail++;
            $display("FAIL zero_in_idle: got {ack,led,busy}=%b want 100", {ACK_O, o_led, o_busy});
        end
        step();
        n_cmp++;
        if (ACK_O !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_in_idle_ack_drop: got ack=%b want 0", ACK_O);
        end
        repeat (4) step();

        DAT_I = 8'hFF;
        STB_I = 1'b1;
        for (int c = 0; c <= LAT; c++) begin
            step();
            if (c == 0) STB_I = 1'b0;
        end
        n_cmp++;
        if ({ACK_O, o_led, o_busy} !== 3'b111) begin
            n_fail++;
            $display("FAIL run_start: got {ack,led,busy}=%b want 111", {ACK_O, o_led, o_busy});
        end
        repeat (6) step();

        // Zero load while running: acknowledged and back to idle.
        DAT_I = 8'h00;
        STB_I = 1'b1;
        for (int c = 0; c <= LAT; c++) begin
            step();
            if (c == 0) STB_I = 1'b0;
        end
        n_cmp++;
        if ({ACK_O, o_led, o_busy} !== 3'b100) begin
            n_fail++;
            $display("FAIL zero_in_run: got {ack,led,busy}=%b want 100", {ACK_O, o_led, o_busy});
        end
        step();
        n_cmp++;
        if ({ACK_O, o_led, o_busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL zero_in_run_after: got {ack,led,busy}=%b want 000", {ACK_O, o_led, o_busy});
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        DAT_I = 8'hFF;
        STB_I = 1'b1;
        step();
        STB_I = 1'b0;
        repeat (LAT + 5) step();
        n_cmp++;
        if ({o_led, o_busy} !== 2'b11) begin
            n_fail++;
            $display("FAIL async_pre: got {led,busy}=%b want 11", {o_led, o_busy});
        end
        // Assert reset mid-cycle and look before the next rising edge.
        #3;
        RST_I = 1'b0;
        #1;
        n_cmp++;
        if ({ACK_O, o_led, o_busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL async_reset: got {ack,led,busy}=%b want 000", {ACK_O, o_led, o_busy});
        end
        step();
        RST_I = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_pattern();
        test_held_strobe();
        test_midrun_reload();
        test_load_zero();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
